// File: rtl/exec_unit_iqueue.sv
// In-order instruction queue in front of the ALPU: buffers dispatch entries, resolves address operands, issues one at a time.
// Optional build macro EXEC_UNIT_IQUEUE_BYPASS_EN lets a push into an empty, idle queue load the head stage directly.
package exec_unit_iqueue_pkg;
    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic [3:0] unit;
        logic [3:0] bank;
        logic [7:0] slot;
    } type_exec_unit_addr;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
    } type_immediate;

    typedef union packed {
        type_exec_unit_addr as_addr;
        type_immediate      as_immediate;
    } type_operand;

    typedef struct packed {
        logic               op0m;
        type_operand        op0;
        logic               op1m;
        type_operand        op1;
        type_exec_unit_addr opd;
    } type_iqueue_entry;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op0_data;
        logic                  op0_valid;
        logic [DATA_WIDTH-1:0] op1_data;
        logic                  op1_valid;
        type_exec_unit_addr    opd_addr;
        logic                  opd_ready;
    } type_alpu_channel_rx;
endpackage

module exec_unit_iqueue
    import exec_unit_iqueue_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int EU_IDX = 0
) (
    input  logic                  i_clk,
    input  logic                  i_nrst,
    input  logic                  i_push_valid,
    input  type_iqueue_entry      i_push_entry,
    output logic                  o_push_ready,
    output logic                  o_op0_rd_req,
    output type_exec_unit_addr    o_op0_rd_addr,
    input  logic                  i_op0_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_op0_rd_data,
    output logic                  o_op1_rd_req,
    output type_exec_unit_addr    o_op1_rd_addr,
    input  logic                  i_op1_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_op1_rd_data,
    input  logic                  i_opd_ready,
    output type_alpu_channel_rx   o_alpu_rx,
    input  logic                  i_alpu_accept
);
    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (EU_IDX < 0)) begin : g_bad_param
        $error("exec_unit_iqueue: DEPTH must be a power of two >= 2 and EU_IDX non-negative");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_ISSUE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    type_iqueue_entry      mem_q [DEPTH];
    type_exec_unit_addr    op0_addr_q, op0_addr_d, op1_addr_q, op1_addr_d;
    type_exec_unit_addr    opd_q, opd_d;
    logic                  op0_res_q, op0_res_d, op1_res_q, op1_res_d;
    logic [DATA_WIDTH-1:0] op0_data_q, op0_data_d, op1_data_q, op1_data_d;

    logic             empty_s, full_s, push_s, bypass_s, fifo_wr_s;
    logic             load_s, pop_s, retire_s, cap0_s, cap1_s;
    type_iqueue_entry load_entry_s;
    type_alpu_channel_rx alpu_rx_s;

    assign empty_s  = (wr_ptr_q == rd_ptr_q);
    assign full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign push_s   = i_push_valid && !full_s;
    assign retire_s = (state_q == ST_ISSUE) && i_alpu_accept && i_opd_ready;

`ifdef EXEC_UNIT_IQUEUE_BYPASS_EN
    assign bypass_s = push_s && empty_s && ((state_q == ST_IDLE) || retire_s);
`else
    assign bypass_s = 1'b0;
`endif

    assign fifo_wr_s    = push_s && !bypass_s;
    assign load_entry_s = pop_s ? mem_q[rd_ptr_q[AW-1:0]] : i_push_entry;

    // Requests are gated by state, so responses outside RESOLVE never capture.
    assign o_op0_rd_req  = (state_q == ST_RESOLVE) && !op0_res_q;
    assign o_op1_rd_req  = (state_q == ST_RESOLVE) && !op1_res_q;
    assign o_op0_rd_addr = op0_addr_q;
    assign o_op1_rd_addr = op1_addr_q;
    assign cap0_s        = o_op0_rd_req && i_op0_rd_valid;
    assign cap1_s        = o_op1_rd_req && i_op1_rd_valid;
    assign o_push_ready  = !full_s;

    // Head-stage next state: new entry on load, otherwise operand captures.
    assign op0_addr_d = load_s ? load_entry_s.op0.as_addr : op0_addr_q;
    assign op1_addr_d = load_s ? load_entry_s.op1.as_addr : op1_addr_q;
    assign opd_d      = load_s ? load_entry_s.opd : opd_q;
    assign op0_res_d  = load_s ? !load_entry_s.op0m : (op0_res_q || cap0_s);
    assign op1_res_d  = load_s ? !load_entry_s.op1m : (op1_res_q || cap1_s);
    assign op0_data_d = load_s ? load_entry_s.op0.as_immediate.data : (cap0_s ? i_op0_rd_data : op0_data_q);
    assign op1_data_d = load_s ? load_entry_s.op1.as_immediate.data : (cap1_s ? i_op1_rd_data : op1_data_q);
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, fifo_wr_s};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop_s};

    // Head FSM next state and FIFO pop/load decisions.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_s  = !empty_s || bypass_s;
                pop_s   = !empty_s;
                state_d = load_s ? ST_RESOLVE : ST_IDLE;
            end
            ST_RESOLVE: begin
                if ((op0_res_q || cap0_s) && (op1_res_q || cap1_s)) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_RESOLVE;
                end
            end
            ST_ISSUE: begin
                if (retire_s) begin
                    load_s  = !empty_s || bypass_s;
                    pop_s   = !empty_s;
                    state_d = load_s ? ST_RESOLVE : ST_IDLE;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FIFO storage; occupancy lives in the pointers, so contents need no reset.
    always_ff @(posedge i_clk) begin
        if (fifo_wr_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_push_entry;
        end
    end

    // State, pointers and head-stage registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            op0_addr_q <= '0;
            op1_addr_q <= '0;
            opd_q      <= '0;
            op0_res_q  <= 1'b0;
            op1_res_q  <= 1'b0;
            op0_data_q <= '0;
            op1_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            op0_addr_q <= op0_addr_d;
            op1_addr_q <= op1_addr_d;
            opd_q      <= opd_d;
            op0_res_q  <= op0_res_d;
            op1_res_q  <= op1_res_d;
            op0_data_q <= op0_data_d;
            op1_data_q <= op1_data_d;
        end
    end

    // ALPU channel; valids and opd_ready only in ISSUE so reset shows all zeros.
    always_comb begin
        alpu_rx_s           = '0;
        alpu_rx_s.op0_data  = op0_data_q;
        alpu_rx_s.op1_data  = op1_data_q;
        alpu_rx_s.op0_valid = (state_q == ST_ISSUE) && op0_res_q;
        alpu_rx_s.op1_valid = (state_q == ST_ISSUE) && op1_res_q;
        alpu_rx_s.opd_addr  = opd_q;
        alpu_rx_s.opd_ready = (state_q == ST_ISSUE) && i_opd_ready;
    end

    assign o_alpu_rx = alpu_rx_s;
endmodule

// File: tb/tb_exec_unit_iqueue.sv
// Self-checking bench for exec_unit_iqueue: vector table, scoreboard of expected issues, operand responder.
module tb_exec_unit_iqueue;
    import exec_unit_iqueue_pkg::*;

    localparam int DEPTH = 8;
`ifdef EXEC_UNIT_IQUEUE_BYPASS_EN
    localparam int LAT_IMM = 1;
`else
    localparam int LAT_IMM = 2;
`endif

    typedef struct {
        logic        op0m;
        logic [15:0] op0;
        logic        op1m;
        logic [15:0] op1;
        logic [15:0] opd;
        int          lat0;
        int          lat1;
        logic [15:0] rsp0;
        logic [15:0] rsp1;
        logic [15:0] exp0;
        logic [15:0] exp1;
    } vec_t;

    logic                clk = 1'b0;
    logic                i_nrst;
    logic                i_push_valid;
    type_iqueue_entry    i_push_entry;
    logic                o_push_ready;
    logic                o_op0_rd_req, o_op1_rd_req;
    type_exec_unit_addr  o_op0_rd_addr, o_op1_rd_addr;
    logic                i_op0_rd_valid, i_op1_rd_valid;
    logic [15:0]         i_op0_rd_data, i_op1_rd_data;
    logic                i_opd_ready;
    type_alpu_channel_rx o_alpu_rx;
    logic                i_alpu_accept;

    int   checks = 0;
    int   errors = 0;
    vec_t exp_q[$];
    vec_t tbl[6];
    vec_t fv;
    int   cnt0, cnt1, req0_cycles, req1_cycles, n;
    logic auto0, auto1, force0;

    exec_unit_iqueue #(.DEPTH(DEPTH), .EU_IDX(0)) dut (
        .i_clk(clk), .i_nrst(i_nrst),
        .i_push_valid(i_push_valid), .i_push_entry(i_push_entry), .o_push_ready(o_push_ready),
        .o_op0_rd_req(o_op0_rd_req), .o_op0_rd_addr(o_op0_rd_addr),
        .i_op0_rd_valid(i_op0_rd_valid), .i_op0_rd_data(i_op0_rd_data),
        .o_op1_rd_req(o_op1_rd_req), .o_op1_rd_addr(o_op1_rd_addr),
        .i_op1_rd_valid(i_op1_rd_valid), .i_op1_rd_data(i_op1_rd_data),
        .i_opd_ready(i_opd_ready), .o_alpu_rx(o_alpu_rx), .i_alpu_accept(i_alpu_accept)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic type_iqueue_entry mk(input vec_t v);
        type_iqueue_entry e;
        e.op0m                    = v.op0m;
        e.op0.as_immediate.data   = v.op0;
        e.op1m                    = v.op1m;
        e.op1.as_immediate.data   = v.op1;
        e.opd                     = type_exec_unit_addr'(v.opd);
        return e;
    endfunction

    // One clock: retire monitor and operand responder at negedge, then return 1 time unit after posedge.
    task automatic tick();
        vec_t v;
        @(negedge clk);
        if (i_nrst && o_alpu_rx.op0_valid && o_alpu_rx.op1_valid && i_alpu_accept && i_opd_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_retire: got retire with opd %0h expected none", o_alpu_rx.opd_addr);
            end else begin
                v = exp_q.pop_front();
                check("issue_op0_data", 64'(o_alpu_rx.op0_data), 64'(v.exp0));
                check("issue_op1_data", 64'(o_alpu_rx.op1_data), 64'(v.exp1));
                check("issue_opd_addr", 64'(o_alpu_rx.opd_addr), 64'(v.opd));
                check("issue_opd_ready", 64'(o_alpu_rx.opd_ready), 64'd1);
            end
        end
        if (o_op0_rd_req) begin
            req0_cycles++;
            cnt0++;
            if (exp_q.size() > 0) begin
                check("op0_rd_addr", 64'(o_op0_rd_addr), 64'(exp_q[0].op0));
                auto0         = (cnt0 >= exp_q[0].lat0);
                i_op0_rd_data = exp_q[0].rsp0;
            end else begin
                auto0 = 1'b0;
            end
        end else begin
            cnt0  = 0;
            auto0 = 1'b0;
        end
        if (o_op1_rd_req) begin
            req1_cycles++;
            cnt1++;
            if (exp_q.size() > 0) begin
                check("op1_rd_addr", 64'(o_op1_rd_addr), 64'(exp_q[0].op1));
                auto1         = (cnt1 >= exp_q[0].lat1);
                i_op1_rd_data = exp_q[0].rsp1;
            end else begin
                auto1 = 1'b0;
            end
        end else begin
            cnt1  = 0;
            auto1 = 1'b0;
        end
        if (force0) i_op0_rd_data = 16'hDEAD;
        i_op0_rd_valid = auto0 | force0;
        i_op1_rd_valid = auto1;
        @(posedge clk);
        #1;
    endtask

    // Push one entry into an empty queue and follow it to retirement.
    task automatic apply_vec(input vec_t v);
        int lat;
        int k;
        check("push_ready_before", 64'(o_push_ready), 64'd1);
        i_push_valid = 1'b1;
        i_push_entry = mk(v);
        exp_q.push_back(v);
        req0_cycles = 0;
        req1_cycles = 0;
        tick();
        i_push_valid = 1'b0;
        check("valid_at_push_edge", 64'(o_alpu_rx.op0_valid), 64'd0);
        if (!v.op0m && !v.op1m) begin
            lat = 0;
            for (k = 1; k <= 6; k++) begin
                tick();
                if (o_alpu_rx.op0_valid && o_alpu_rx.op1_valid) begin
                    lat = k;
                    break;
                end
            end
            check("imm_latency", 64'(lat), 64'(LAT_IMM));
        end
        k = 0;
        while (exp_q.size() > 0 && k < 40) begin
            tick();
            k++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL retire_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        check("req0_cycles", 64'(req0_cycles), 64'(v.op0m ? v.lat0 : 0));
        check("req1_cycles", 64'(req1_cycles), 64'(v.op1m ? v.lat1 : 0));
        check("idle_after_retire",
              64'({o_alpu_rx.op0_valid, o_alpu_rx.op1_valid, o_op0_rd_req, o_op1_rd_req}), 64'd0);
    endtask

    initial begin
        i_nrst = 1'b0; i_push_valid = 1'b0; i_push_entry = '0;
        i_op0_rd_valid = 1'b0; i_op1_rd_valid = 1'b0; i_op0_rd_data = '0; i_op1_rd_data = '0;
        i_opd_ready = 1'b0; i_alpu_accept = 1'b0;
        cnt0 = 0; cnt1 = 0; req0_cycles = 0; req1_cycles = 0; auto0 = 1'b0; auto1 = 1'b0; force0 = 1'b0;

        //      op0m  op0       op1m  op1       opd       lat0 lat1 rsp0      rsp1      exp0      exp1
        tbl[0] = '{1'b0, 16'h0005, 1'b0, 16'h0003, 16'h0104, 0, 0, 16'h0000, 16'h0000, 16'h0005, 16'h0003};
        tbl[1] = '{1'b1, 16'h0207, 1'b0, 16'h0011, 16'h0301, 3, 0, 16'h00AA, 16'h0000, 16'h00AA, 16'h0011};
        tbl[2] = '{1'b0, 16'h1234, 1'b1, 16'h0A0F, 16'h0002, 0, 1, 16'h0000, 16'hBEEF, 16'h1234, 16'hBEEF};
        tbl[3] = '{1'b1, 16'h0110, 1'b1, 16'h0220, 16'h0F0F, 2, 4, 16'h5555, 16'hAAAA, 16'h5555, 16'hAAAA};
        tbl[4] = '{1'b1, 16'h0333, 1'b1, 16'h0444, 16'h0A0B, 1, 1, 16'h0001, 16'h0002, 16'h0001, 16'h0002};
        tbl[5] = '{1'b0, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000};

        tick();
        tick();
        check("reset_rx", 64'(o_alpu_rx), 64'd0);
        check("reset_reqs", 64'({o_op0_rd_req, o_op1_rd_req}), 64'd0);
        check("reset_addrs", 64'({o_op0_rd_addr, o_op1_rd_addr}), 64'd0);
        check("reset_push_ready", 64'(o_push_ready), 64'd1);
        i_nrst = 1'b1;
        tick();

        i_alpu_accept = 1'b1;
        i_opd_ready   = 1'b1;
        for (int i = 0; i < 6; i++) apply_vec(tbl[i]);

        // Fill: head plus DEPTH FIFO slots hold DEPTH+1 entries, the next push is dropped.
        i_alpu_accept = 1'b0;
        for (int k = 0; k < DEPTH + 2; k++) begin
            fv = '{1'b0, 16'h0100 + 16'(k), 1'b0, 16'h0200 + 16'(k), 16'h0000 + 16'(k), 0, 0,
                   16'h0000, 16'h0000, 16'h0100 + 16'(k), 16'h0200 + 16'(k)};
            check("fill_push_ready", 64'(o_push_ready), 64'(k <= DEPTH));
            i_push_valid = 1'b1;
            i_push_entry = mk(fv);
            if (k <= DEPTH) exp_q.push_back(fv);
            tick();
        end
        i_push_valid = 1'b0;
        check("full_push_ready", 64'(o_push_ready), 64'd0);
        check("head_waiting_valid", 64'(o_alpu_rx.op0_valid), 64'd1);
        i_alpu_accept = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 60) begin
            tick();
            n++;
        end
        check("drain_cycles", 64'(n), 64'(2 * DEPTH + 1));
        check("drain_pending", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        check("drain_push_ready", 64'(o_push_ready), 64'd1);
        check("drain_idle", 64'(o_alpu_rx.op0_valid), 64'd0);

        // Accept without opd_ready must hold the instruction.
        i_opd_ready = 1'b0;
        fv = '{1'b0, 16'h0042, 1'b0, 16'h0024, 16'h0506, 0, 0, 16'h0000, 16'h0000, 16'h0042, 16'h0024};
        i_push_valid = 1'b1;
        i_push_entry = mk(fv);
        exp_q.push_back(fv);
        tick();
        i_push_valid = 1'b0;
        n = 0;
        while (!o_alpu_rx.op0_valid && n < 6) begin
            tick();
            n++;
        end
        check("hold_reached_issue", 64'(o_alpu_rx.op0_valid), 64'd1);
        for (int k = 0; k < 4; k++) begin
            check("hold_valids", 64'({o_alpu_rx.op0_valid, o_alpu_rx.op1_valid}), 64'h3);
            check("hold_op0_data", 64'(o_alpu_rx.op0_data), 64'h0042);
            check("hold_op1_data", 64'(o_alpu_rx.op1_data), 64'h0024);
            check("hold_opd_addr", 64'(o_alpu_rx.opd_addr), 64'h0506);
            check("hold_opd_ready", 64'(o_alpu_rx.opd_ready), 64'd0);
            tick();
        end
        i_opd_ready = 1'b1;
        #1;
        check("opd_ready_passthru", 64'(o_alpu_rx.opd_ready), 64'd1);
        tick();
        check("hold_retired", 64'(exp_q.size()), 64'd0);
        check("hold_idle", 64'(o_alpu_rx.op0_valid), 64'd0);
        exp_q.delete();

        // Reset mid-RESOLVE with both requests outstanding, then a late response.
        fv = '{1'b1, 16'h0123, 1'b1, 16'h0456, 16'h0789, 100, 100, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        i_push_valid = 1'b1;
        i_push_entry = mk(fv);
        exp_q.push_back(fv);
        tick();
        i_push_valid = 1'b0;
        n = 0;
        while (!(o_op0_rd_req && o_op1_rd_req) && n < 6) begin
            tick();
            n++;
        end
        check("both_reqs_before_reset", 64'({o_op0_rd_req, o_op1_rd_req}), 64'h3);
        tick();
        i_nrst = 1'b0;
        #1;
        exp_q.delete();
        check("midreset_rx", 64'(o_alpu_rx), 64'd0);
        check("midreset_reqs", 64'({o_op0_rd_req, o_op1_rd_req}), 64'd0);
        check("midreset_addrs", 64'({o_op0_rd_addr, o_op1_rd_addr}), 64'd0);
        check("midreset_push_ready", 64'(o_push_ready), 64'd1);
        tick();
        tick();
        i_nrst = 1'b1;
        force0 = 1'b1;
        tick();
        force0 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("late_rsp_ignored",
                  64'({o_alpu_rx.op0_valid, o_alpu_rx.op1_valid, o_op0_rd_req, o_op1_rd_req}), 64'd0);
        end
        check("post_reset_push_ready", 64'(o_push_ready), 64'd1);
        apply_vec(tbl[5]);
        apply_vec(tbl[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
